// File: rtl/md5_msg_sequencer.sv
// MD5 front end: pads a 32-bit word stream, slices it into 512-bit blocks, chains state through the core.
// Latency: last beat accept -> pad cycles + 1 ISSUE + core time + 1 DONE -> DIGEST_VALID_OUT.
// Backpressure: MSG_READY_OUT drops while a block is padded, issued or in the core; beats offered then are held, not lost.
module md5_msg_sequencer #(
    parameter int LEN_W = 32
) (
    input  logic         PCLK_IN,
    input  logic         PRESET_IN,
    input  logic         MSG_VALID_IN,
    output logic         MSG_READY_OUT,
    input  logic [31:0]  MSG_DATA_IN,
    input  logic         MSG_LAST_IN,
    input  logic [2:0]   MSG_NBYTES_IN,
    output logic         CORE_START_OUT,
    output logic [511:0] CORE_BLOCK_OUT,
    output logic [127:0] CORE_IV_OUT,
    input  logic         CORE_DONE_IN,
    input  logic [127:0] CORE_DIGEST_IN,
    output logic [127:0] DIGEST_OUT,
    output logic         DIGEST_VALID_OUT,
    output logic         BUSY_OUT
);

    localparam logic [127:0] IV_INIT = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      blk_q [16];
    logic [4:0]       widx_q;
    logic [LEN_W-1:0] bytecnt_q;
    logic [127:0]     iv_q;
    logic [127:0]     digest_q;
    logic             msg_done_q;   // last beat of the message has been accepted
    logic             need80_q;     // 0x80 word still to be written by PAD
    logic             carry80_q;    // 0x80 word belongs at index 0 of the next block
    logic             spill_q;      // 0x80 landed at 14/15: this block is zero-filled, length goes in a fresh block
    logic             len_wr_q;     // current block carries the bit length (final block)

    logic             load_st;
    logic             accept;
    logic [2:0]       nb_eff;
    logic [31:0]      beat_word;
    logic [63:0]      bitlen;
    logic [31:0]      pad_word;
    logic [511:0]     blk_flat;
    logic             hold;

    // Beat acceptance, last-beat byte masking with the 0x80 marker, and PAD word selection
    always_comb begin
        load_st = (state_q == S_IDLE) || (state_q == S_LOAD);
        MSG_READY_OUT = load_st && !widx_q[4] && !PRESET_IN;
        accept  = MSG_VALID_IN && MSG_READY_OUT;
        nb_eff  = 3'd4;
        if (MSG_LAST_IN && (MSG_NBYTES_IN < 3'd4))
            nb_eff = MSG_NBYTES_IN;
        case (nb_eff)
            3'd0:    beat_word = 32'h0000_0080;
            3'd1:    beat_word = {16'h0000, 8'h80, MSG_DATA_IN[7:0]};
            3'd2:    beat_word = {8'h00, 8'h80, MSG_DATA_IN[15:0]};
            3'd3:    beat_word = {8'h80, MSG_DATA_IN[23:0]};
            default: beat_word = MSG_DATA_IN;
        endcase
        bitlen = 64'({bytecnt_q, 3'b000});
        if (need80_q)
            pad_word = 32'h0000_0080;
        else if (spill_q || (widx_q < 5'd14))
            pad_word = 32'h0000_0000;
        else if (!widx_q[0])
            pad_word = bitlen[31:0];
        else
            pad_word = bitlen[63:32];
    end

    // State register
    always_ff @(posedge PCLK_IN) begin
        if (PRESET_IN)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (widx_q == 5'd15)
                        state_d = S_ISSUE;
                    else if (MSG_LAST_IN)
                        state_d = S_PAD;
                    else
                        state_d = S_LOAD;
                end
            end
            S_PAD:   if (widx_q == 5'd15) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (CORE_DONE_IN) begin
                    if (!msg_done_q)
                        state_d = S_LOAD;
                    else if (len_wr_q)
                        state_d = S_DONE;
                    else
                        state_d = S_PAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Block buffer, word index, byte counter, chaining state and padding flags
    always_ff @(posedge PCLK_IN) begin
        if (PRESET_IN) begin
            for (int i = 0; i < 16; i++)
                blk_q[i] <= 32'h0;
            widx_q     <= 5'd0;
            bytecnt_q  <= '0;
            iv_q       <= IV_INIT;
            digest_q   <= 128'h0;
            msg_done_q <= 1'b0;
            need80_q   <= 1'b0;
            carry80_q  <= 1'b0;
            spill_q    <= 1'b0;
            len_wr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        blk_q[widx_q[3:0]] <= beat_word;
                        widx_q <= widx_q + 5'd1;
                        if (state_q == S_IDLE) begin
                            iv_q      <= IV_INIT;
                            bytecnt_q <= LEN_W'(nb_eff);
                        end else begin
                            bytecnt_q <= bytecnt_q + LEN_W'(nb_eff);
                        end
                        if (MSG_LAST_IN) begin
                            msg_done_q <= 1'b1;
                            if (nb_eff == 3'd4) begin
                                if (widx_q == 5'd15)
                                    carry80_q <= 1'b1;
                                else
                                    need80_q <= 1'b1;
                            end else if (widx_q >= 5'd14) begin
                                spill_q <= 1'b1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    blk_q[widx_q[3:0]] <= pad_word;
                    widx_q <= widx_q + 5'd1;
                    if (need80_q) begin
                        need80_q <= 1'b0;
                        if (widx_q >= 5'd14)
                            spill_q <= 1'b1;
                    end else if (!spill_q && (widx_q == 5'd15)) begin
                        len_wr_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (CORE_DONE_IN) begin
                        iv_q    <= CORE_DIGEST_IN;
                        spill_q <= 1'b0;
                        if (carry80_q) begin
                            blk_q[0]  <= 32'h0000_0080;
                            widx_q    <= 5'd1;
                            carry80_q <= 1'b0;
                        end else begin
                            widx_q <= 5'd0;
                        end
                        if (msg_done_q && len_wr_q)
                            digest_q <= CORE_DIGEST_IN;
                    end
                end
                S_DONE: begin
                    msg_done_q <= 1'b0;
                    len_wr_q   <= 1'b0;
                    widx_q     <= 5'd0;
                end
                default: ;
            endcase
        end
    end

    // Core and status outputs; block/IV shown only while the core owns them
    always_comb begin
        for (int i = 0; i < 16; i++)
            blk_flat[32*i +: 32] = blk_q[i];
        hold             = (state_q == S_ISSUE) || (state_q == S_WAIT);
        CORE_START_OUT   = (state_q == S_ISSUE);
        CORE_BLOCK_OUT   = hold ? blk_flat : 512'h0;
        CORE_IV_OUT      = hold ? iv_q : 128'h0;
        DIGEST_OUT       = digest_q;
        DIGEST_VALID_OUT = (state_q == S_DONE);
        BUSY_OUT         = (state_q != S_IDLE);
    end

endmodule
